// File: rtl/gaussian_line_buffer_pkg.sv
// Shared constants, state encoding and row-geometry helper for the
// Gaussian line buffer.
package gaussian_pkg;

  localparam int DATA_WIDTH  = 512;
  localparam int PIXEL_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TOP   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } t_gaussian_lb_state;

  // Number of bus beats that carry one image row.
  function automatic int beats_per_row(input int image_width, input int pixel_width,
                                       input int data_width);
    return (image_width * pixel_width) / data_width;
  endfunction

endpackage

// File: rtl/gaussian_line_buffer_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Contents are not reset; every location is written before it is read.
module gaussian_lb_ram
  import gaussian_pkg::*;
#(
  parameter int DEPTH  = 30,
  parameter int WIDTH  = DATA_WIDTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gaussian_line_buffer.sv
// Gaussian line buffer: turns a raster beat stream into a 3-row vertical
// window (rows r-2, r-1, r) using two line RAMs.
// Optional edge replication (extra top window row and bottom flush) is
// enabled with `define GAUSSIAN_LINE_BUFFER_BORDER_EN.
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int DATA_WIDTH   = gaussian_pkg::DATA_WIDTH,
  parameter int PIXEL_WIDTH  = gaussian_pkg::PIXEL_WIDTH,
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] win_top,
  output logic [DATA_WIDTH-1:0] win_mid,
  output logic [DATA_WIDTH-1:0] win_bot,
  output logic                  valid_out,
  output logic                  sol,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  overflow_err
);

  localparam int BEATS = beats_per_row(IMAGE_WIDTH, PIXEL_WIDTH, DATA_WIDTH);
  localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  t_gaussian_lb_state state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic col_last, row_last, accept, rd_en;
  logic emit, eof_c, top_rep, flush_c;

  // Stage 1: RAM read in flight, beat registered for the write-back
  logic                  s1_wr, s1_emit, s1_sol, s1_eol, s1_eof, s1_top_rep, s1_flush;
  logic [COL_W-1:0]      s1_col;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] rd0, rd1;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
  // Beats arriving while the bottom border is flushed are dropped.
  assign accept = valid_in && (state != FLUSH);
`else
  assign accept = valid_in;
`endif
  assign rd_en = accept | flush_c;

  // State / counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Next state, counters and per-beat window flags
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    emit      = 1'b0;
    eof_c     = 1'b0;
    top_rep   = 1'b0;
    flush_c   = 1'b0;
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
    if (state == FLUSH) begin
      // Self-issued reads replay the last row as the bottom neighbour.
      emit    = 1'b1;
      flush_c = 1'b1;
      col_nxt = col_last ? '0 : col + 1'b1;
      if (col_last) begin
        eof_c     = 1'b1;
        state_nxt = FILL;
      end
    end else
`endif
    if (valid_in) begin
      col_nxt = col_last ? '0 : col + 1'b1;
      case (state)
        FILL: begin
          if (col_last) begin
            row_nxt = row + 1'b1;
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
            state_nxt = TOP;
`else
            if (row == ROW_W'(1)) state_nxt = RUN;
`endif
          end
        end
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
        TOP: begin
          // Row 0 stands in for the missing row above it.
          emit    = 1'b1;
          top_rep = 1'b1;
          if (col_last) begin
            row_nxt   = row + 1'b1;
            state_nxt = RUN;
          end
        end
`endif
        RUN: begin
          emit = 1'b1;
          if (col_last) begin
            if (row_last) begin
              row_nxt = '0;
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
              state_nxt = FLUSH;
`else
              eof_c     = 1'b1;
              state_nxt = FILL;
`endif
            end else begin
              row_nxt = row + 1'b1;
            end
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // Stage 1 control pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_wr      <= 1'b0;
      s1_emit    <= 1'b0;
      s1_sol     <= 1'b0;
      s1_eol     <= 1'b0;
      s1_eof     <= 1'b0;
      s1_top_rep <= 1'b0;
      s1_flush   <= 1'b0;
      s1_col     <= '0;
    end else begin
      s1_wr      <= accept;
      s1_emit    <= emit;
      s1_sol     <= (col == '0);
      s1_eol     <= col_last;
      s1_eof     <= eof_c;
      s1_top_rep <= top_rep;
      s1_flush   <= flush_c;
      s1_col     <= col;
    end
  end

  // Stage 1 beat data, only meaningful alongside s1_wr
  always_ff @(posedge clk) begin
    if (accept) s1_data <= data_in;
  end

  // line0 holds row r-1; line1 holds row r-2 (shifted down from line0)
  gaussian_lb_ram #(.DEPTH(BEATS), .WIDTH(DATA_WIDTH)) u_line0 (
    .clk(clk), .we(s1_wr), .waddr(s1_col), .wdata(s1_data),
    .re(rd_en), .raddr(col), .rdata(rd0)
  );

  gaussian_lb_ram #(.DEPTH(BEATS), .WIDTH(DATA_WIDTH)) u_line1 (
    .clk(clk), .we(s1_wr), .waddr(s1_col), .wdata(rd0),
    .re(rd_en), .raddr(col), .rdata(rd1)
  );

  // Registered window outputs and frame status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_top   <= '0;
      win_mid   <= '0;
      win_bot   <= '0;
      valid_out <= 1'b0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= s1_emit;
      sol       <= s1_emit & s1_sol;
      eol       <= s1_emit & s1_eol;
      eof       <= s1_emit & s1_eof;
      if (s1_emit) begin
        win_top <= s1_top_rep ? rd0 : rd1;
        win_mid <= rd0;
        win_bot <= s1_flush ? rd0 : s1_data;
      end
      // A next frame may already be under way when eof leaves the pipe.
      if (accept) busy <= 1'b1;
      else if (valid_out && eof) busy <= (row != '0) || (col != '0);
    end
  end

`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
  // Sticky flag: a beat was dropped during the bottom flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_err <= 1'b0;
    else if (valid_in && (state == FLUSH)) overflow_err <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_gaussian_line_buffer.sv
// Scoreboard bench for gaussian_line_buffer: 128x4 image, 2 beats per row.
module tb_gaussian_line_buffer;

  localparam int DW = 512;
  localparam int IW = 128;
  localparam int IH = 4;
  localparam int BEATS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] win_top, win_mid, win_bot;
  logic          valid_out, sol, eol, eof, busy, overflow_err;

  gaussian_line_buffer #(
    .DATA_WIDTH(DW), .PIXEL_WIDTH(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
    .valid_out(valid_out), .sol(sol), .eol(eol), .eof(eof),
    .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] top, mid, bot;
    logic          sol, eol, eof;
    int            due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] beat(input int r, input int c, input logic [7:0] off);
    logic [7:0] b;
    b = 8'(r * 16 + c) + off;
    return {64{b}};
  endfunction

  function automatic void push(input logic [DW-1:0] t, input logic [DW-1:0] m,
                               input logic [DW-1:0] b, input logic s, input logic l,
                               input logic f, input int due);
    exp_t x;
    x.top = t; x.mid = m; x.bot = b; x.sol = s; x.eol = l; x.eof = f; x.due = due;
    q.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one beat at the current negedge and queue the windows it produces.
  task automatic send_beat(input int r, input int c, input logic [7:0] off, input bit expect_win);
    bit last_eof;
    valid_in = 1'b1;
    data_in  = beat(r, c, off);
    if (expect_win) begin
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
      last_eof = 1'b0;
      if (r == 1)
        push(beat(0, c, off), beat(0, c, off), beat(1, c, off), c == 0, c == BEATS-1, 1'b0, cyc + 2);
`else
      last_eof = (r == IH-1) && (c == BEATS-1);
`endif
      if (r >= 2)
        push(beat(r-2, c, off), beat(r-1, c, off), beat(r, c, off), c == 0, c == BEATS-1,
             last_eof, cyc + 2);
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
      if (r == IH-1 && c == BEATS-1)
        for (int k = 0; k < BEATS; k++)
          push(beat(IH-2, k, off), beat(IH-1, k, off), beat(IH-1, k, off), k == 0,
               k == BEATS-1, k == BEATS-1, cyc + 3 + k);
`endif
    end
    @(negedge clk);
    valid_in = 1'b0;
    chk("busy_in_frame", busy, 1);
  endtask

  task automatic send_frame(input logic [7:0] off, input int gap_max);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < BEATS; c++) begin
        if (gap_max > 0 && (r != 0 || c != 0))
          repeat ($urandom_range(0, gap_max)) @(negedge clk);
        send_beat(r, c, off, 1'b1);
      end
  endtask

  task automatic wait_eof();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (valid_out && eof) seen = 1'b1;
    end
    chk("eof_seen", DW'(seen), 1);
    @(negedge clk);
    chk("busy_after_eof", busy, 0);
  endtask

  // Monitor: every presented window must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got top %0h, expected no window", win_top);
      end else begin
        e = q.pop_front();
        chk("win_top", win_top, e.top);
        chk("win_mid", win_mid, e.mid);
        chk("win_bot", win_bot, e.bot);
        chk("sol", sol, e.sol);
        chk("eol", eol, e.eol);
        chk("eof", eof, e.eof);
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sol_eol_eof", {sol, eol, eof}, 0);
    chk("rst_win_top", win_top, 0);
    chk("rst_win_bot", win_bot, 0);
    chk("rst_overflow", overflow_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Contiguous frame
    send_frame(8'h00, 0);
    wait_eof();

    // Same frame with random idle gaps between beats
    send_frame(8'h00, 3);
    wait_eof();

    // Two frames; second offset by 0x80
    send_frame(8'h00, 0);
`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
    wait_eof();
`endif
    send_frame(8'h80, 0);
    wait_eof();

    // Reset in the middle of a frame, right after beat (2,0)
    send_beat(0, 0, 8'h00, 1'b1);
    send_beat(0, 1, 8'h00, 1'b1);
    send_beat(1, 0, 8'h00, 1'b1);
    send_beat(1, 1, 8'h00, 1'b1);
    send_beat(2, 0, 8'h00, 1'b0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_win_mid", win_mid, 0);
    reset = 1'b0;
    @(negedge clk);
    send_frame(8'h40, 0);
    wait_eof();

`ifdef GAUSSIAN_LINE_BUFFER_BORDER_EN
    // A beat during the bottom flush is dropped and flagged
    send_frame(8'h00, 0);
    valid_in = 1'b1;
    data_in  = {64{8'hEE}};
    @(negedge clk);
    valid_in = 1'b0;
    wait_eof();
    chk("overflow_set", overflow_err, 1);
`else
    chk("overflow_zero", overflow_err, 0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
